// File: rtl/sparse_encoder_if.sv
// Dense-in / sparse-out stream bundle for the zero-skipping encoder.
// master = encoder side, slave = producer/consumer side.
interface sparse_encoder_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_value;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;
  logic [IDX_W:0]    nnz_count;
  logic              nnz_done;
  logic              overflow;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_index,
    output out_last, nnz_count, nnz_done, overflow
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_index,
    input  out_last, nnz_count, nnz_done, overflow
  );
endinterface

// File: rtl/sparse_encoder.sv
// Zero-skipping encoder: dense activations in, (value, index) pairs out
// through a small FIFO, plus a per-vector nonzero count.
module sparse_encoder #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  sparse_encoder_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic              last_q [DEPTH];

  logic [AW:0]      wp, rp;
  logic [IDX_W-1:0] pos;
  logic [IDX_W:0]   cnt;
  logic [IDX_W:0]   nnz_q;
  logic             done_q;
  logic             ovf_q;

  logic full, empty, acc, nz, push, pop;

  // Extra pointer bit tells full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign acc  = bus.in_valid && bus.in_ready;
  assign nz   = |bus.in_data;
  assign push = acc && (nz || bus.in_last);
  assign pop  = !empty && bus.out_ready;

  assign bus.in_ready  = !full && !rst;
  assign bus.out_valid = !empty;
  assign bus.out_value = empty ? '0 : val_q[rp[AW-1:0]];
  assign bus.out_index = empty ? '0 : idx_q[rp[AW-1:0]];
  assign bus.out_last  = empty ? 1'b0 : last_q[rp[AW-1:0]];
  assign bus.nnz_count = nnz_q;
  assign bus.nnz_done  = done_q;
  assign bus.overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      val_q[wp[AW-1:0]]  <= bus.in_data;
      idx_q[wp[AW-1:0]]  <= pos;
      last_q[wp[AW-1:0]] <= bus.in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      pos    <= '0;
      cnt    <= '0;
      nnz_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push)
        wp <= wp + (AW+1)'(1);
      if (pop)
        rp <= rp + (AW+1)'(1);
      if (acc) begin
        if (bus.in_last) begin
          pos    <= '0;
          cnt    <= '0;
          nnz_q  <= cnt + (IDX_W+1)'(nz);
          done_q <= 1'b1;
        end else begin
          pos <= pos + IDX_W'(1);
          cnt <= cnt + (IDX_W+1)'(nz);
          if (pos == '1)
            ovf_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder: main instance with IDX_W=8,
// second instance with IDX_W=3 for the index-overflow case.
module tb_sparse_encoder;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   pass  = 0;
  int   total = 0;

  always #5 clk = ~clk;

  sparse_encoder_if #(.DATA_W(8), .IDX_W(8)) b ();
  sparse_encoder_if #(.DATA_W(8), .IDX_W(3)) b2 ();

  sparse_encoder #(.DATA_W(8), .IDX_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );

  sparse_encoder #(.DATA_W(8), .IDX_W(3), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst2), .bus(b2)
  );

  task automatic drive(input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    b.in_data  = d;
    b.in_last  = l;
    b.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL drive_timeout data=%0d in_ready=%b need 1", d, b.in_ready);
    end
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
  endtask

  task automatic drive2(input logic [7:0] d, input logic l);
    b2.in_data  = d;
    b2.in_last  = l;
    b2.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b2.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (b.in_ready !== 1'b0)
      $display("FAIL reset_in_ready got=%b need=0", b.in_ready);
    else pass++;
    total++;
    if ({b.out_valid, b.out_value, b.out_index, b.out_last,
         b.nnz_count, b.nnz_done, b.overflow} !== 29'd0)
      $display("FAIL reset_outputs got v=%b val=%0d idx=%0d l=%b n=%0d d=%b o=%b need all 0",
               b.out_valid, b.out_value, b.out_index, b.out_last,
               b.nnz_count, b.nnz_done, b.overflow);
    else pass++;
    rst  = 1'b0;
    rst2 = 1'b0;
    #1;
    total++;
    if (b.in_ready !== 1'b1)
      $display("FAIL reset_release_ready got=%b need=1", b.in_ready);
    else pass++;
  endtask

  task automatic test_basic();
    logic [7:0]  d [8];
    logic [17:0] e;
    d = '{8'd0, 8'd0, 8'd0, 8'd25, 8'd0, 8'd5, 8'd0, 8'd4};
    b.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(d[i], i == 7);
      e = {1'b1, d[i], 8'(i), i == 7};
      total++;
      if (d[i] != 0) begin
        if ({b.out_valid, b.out_value, b.out_index, b.out_last} !== e)
          $display("FAIL basic_out[%0d] got=%h need=%h", i,
                   {b.out_valid, b.out_value, b.out_index, b.out_last}, e);
        else pass++;
      end else begin
        if (b.out_valid !== 1'b0)
          $display("FAIL basic_skip[%0d] out_valid got=%b need=0", i, b.out_valid);
        else pass++;
      end
    end
    total++;
    if ({b.nnz_done, b.nnz_count} !== {1'b1, 9'd3})
      $display("FAIL basic_nnz got done=%b cnt=%0d need done=1 cnt=3",
               b.nnz_done, b.nnz_count);
    else pass++;
    @(posedge clk);
    #1;
    total++;
    if ({b.nnz_done, b.nnz_count, b.out_valid} !== {1'b0, 9'd3, 1'b0})
      $display("FAIL basic_pulse got done=%b cnt=%0d v=%b need done=0 cnt=3 v=0",
               b.nnz_done, b.nnz_count, b.out_valid);
    else pass++;
  endtask

  task automatic test_all_zero();
    drive(8'd0, 1'b0);
    drive(8'd0, 1'b0);
    total++;
    if (b.out_valid !== 1'b0)
      $display("FAIL zero_skip out_valid got=%b need=0", b.out_valid);
    else pass++;
    drive(8'd0, 1'b1);
    total++;
    if ({b.out_valid, b.out_value, b.out_index, b.out_last} !== {1'b1, 8'd0, 8'd2, 1'b1})
      $display("FAIL zero_term got=%h need=%h",
               {b.out_valid, b.out_value, b.out_index, b.out_last},
               {1'b1, 8'd0, 8'd2, 1'b1});
    else pass++;
    total++;
    if ({b.nnz_done, b.nnz_count} !== {1'b1, 9'd0})
      $display("FAIL zero_nnz got done=%b cnt=%0d need done=1 cnt=0",
               b.nnz_done, b.nnz_count);
    else pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    b.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 1), 1'b0);
      total++;
      if ({b.out_valid, b.out_value, b.out_index, b.out_last} !== {1'b1, 8'd1, 8'd0, 1'b0})
        $display("FAIL bp_head[%0d] got=%h need=%h", i,
                 {b.out_valid, b.out_value, b.out_index, b.out_last},
                 {1'b1, 8'd1, 8'd0, 1'b0});
      else pass++;
    end
    total++;
    if (b.in_ready !== 1'b0)
      $display("FAIL bp_full in_ready got=%b need=0", b.in_ready);
    else pass++;
    @(posedge clk);
    #1;
    total++;
    if ({b.in_ready, b.out_value} !== {1'b0, 8'd1})
      $display("FAIL bp_hold got rdy=%b val=%0d need rdy=0 val=1",
               b.in_ready, b.out_value);
    else pass++;
    fork
      begin
        drive(8'd5, 1'b0);
        drive(8'd6, 1'b1);
        total++;
        if ({b.nnz_done, b.nnz_count} !== {1'b1, 9'd6})
          $display("FAIL bp_nnz got done=%b cnt=%0d need done=1 cnt=6",
                   b.nnz_done, b.nnz_count);
        else pass++;
      end
      begin
        b.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          for (int w = 0; w < 20 && !b.out_valid; w++) begin
            @(posedge clk);
            #1;
          end
          total++;
          if ({b.out_valid, b.out_value, b.out_index, b.out_last} !==
              {1'b1, 8'(k + 1), 8'(k), k == 5})
            $display("FAIL bp_order[%0d] got=%h need=%h", k,
                     {b.out_valid, b.out_value, b.out_index, b.out_last},
                     {1'b1, 8'(k + 1), 8'(k), k == 5});
          else pass++;
          @(posedge clk);
          #1;
          if (k == 0) begin
            total++;
            if (b.in_ready !== 1'b1)
              $display("FAIL bp_ready_return got=%b need=1", b.in_ready);
            else pass++;
          end
        end
      end
    join
    total++;
    if (b.out_valid !== 1'b0)
      $display("FAIL bp_drained out_valid got=%b need=0", b.out_valid);
    else pass++;
  endtask

  task automatic test_back_to_back();
    b.out_ready = 1'b1;
    drive(8'd7, 1'b0);
    total++;
    if ({b.out_valid, b.out_value, b.out_index, b.out_last} !== {1'b1, 8'd7, 8'd0, 1'b0})
      $display("FAIL b2b_a0 got=%h need=%h",
               {b.out_valid, b.out_value, b.out_index, b.out_last},
               {1'b1, 8'd7, 8'd0, 1'b0});
    else pass++;
    drive(8'd0, 1'b1);
    total++;
    if ({b.out_valid, b.out_value, b.out_index, b.out_last,
         b.nnz_done, b.nnz_count} !== {1'b1, 8'd0, 8'd1, 1'b1, 1'b1, 9'd1})
      $display("FAIL b2b_a1 got v=%b val=%0d idx=%0d l=%b d=%b n=%0d need 1,0,1,1,1,1",
               b.out_valid, b.out_value, b.out_index, b.out_last,
               b.nnz_done, b.nnz_count);
    else pass++;
    drive(8'd0, 1'b0);
    total++;
    if ({b.out_valid, b.nnz_done} !== 2'b00)
      $display("FAIL b2b_b0 got v=%b d=%b need 0,0", b.out_valid, b.nnz_done);
    else pass++;
    drive(8'd9, 1'b1);
    total++;
    if ({b.out_valid, b.out_value, b.out_index, b.out_last,
         b.nnz_done, b.nnz_count} !== {1'b1, 8'd9, 8'd1, 1'b1, 1'b1, 9'd1})
      $display("FAIL b2b_b1 got v=%b val=%0d idx=%0d l=%b d=%b n=%0d need 1,9,1,1,1,1",
               b.out_valid, b.out_value, b.out_index, b.out_last,
               b.nnz_done, b.nnz_count);
    else pass++;
    drive(8'd5, 1'b1);
    total++;
    if ({b.out_value, b.out_index, b.out_last, b.nnz_done, b.nnz_count} !==
        {8'd5, 8'd0, 1'b1, 1'b1, 9'd1})
      $display("FAIL b2b_c got val=%0d idx=%0d l=%b d=%b n=%0d need 5,0,1,1,1",
               b.out_value, b.out_index, b.out_last, b.nnz_done, b.nnz_count);
    else pass++;
    drive(8'd0, 1'b1);
    total++;
    if ({b.out_value, b.out_index, b.out_last, b.nnz_done, b.nnz_count} !==
        {8'd0, 8'd0, 1'b1, 1'b1, 9'd0})
      $display("FAIL b2b_d got val=%0d idx=%0d l=%b d=%b n=%0d need 0,0,1,1,0",
               b.out_value, b.out_index, b.out_last, b.nnz_done, b.nnz_count);
    else pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    b2.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive2(8'(i + 1), i == 8);
      total++;
      if ({b2.out_valid, b2.out_value, b2.out_index, b2.out_last} !==
          {1'b1, 8'(i + 1), 3'(i), i == 8})
        $display("FAIL ovf_out[%0d] got=%h need=%h", i,
                 {b2.out_valid, b2.out_value, b2.out_index, b2.out_last},
                 {1'b1, 8'(i + 1), 3'(i), i == 8});
      else pass++;
      if (i == 6 || i == 7) begin
        total++;
        if (b2.overflow !== (i == 7))
          $display("FAIL ovf_flag[%0d] got=%b need=%b", i, b2.overflow, i == 7);
        else pass++;
      end
    end
    total++;
    if ({b2.nnz_done, b2.nnz_count} !== {1'b1, 4'd9})
      $display("FAIL ovf_nnz got done=%b cnt=%0d need done=1 cnt=9",
               b2.nnz_done, b2.nnz_count);
    else pass++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (b2.overflow !== 1'b1)
      $display("FAIL ovf_sticky got=%b need=1", b2.overflow);
    else pass++;
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    total++;
    if (b2.overflow !== 1'b0)
      $display("FAIL ovf_clear got=%b need=0", b2.overflow);
    else pass++;
  endtask

  task automatic test_mid_reset();
    b.out_ready = 1'b0;
    drive(8'd1, 1'b0);
    drive(8'd2, 1'b0);
    drive(8'd3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (b.in_ready !== 1'b0)
      $display("FAIL mid_rst_ready got=%b need=0", b.in_ready);
    else pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({b.out_valid, b.out_value, b.nnz_done, b.nnz_count} !== {1'b0, 8'd0, 1'b0, 9'd0})
      $display("FAIL mid_rst_state got v=%b val=%0d d=%b n=%0d need 0,0,0,0",
               b.out_valid, b.out_value, b.nnz_done, b.nnz_count);
    else pass++;
    @(posedge clk);
    #1;
    total++;
    if ({b.out_valid, b.nnz_done} !== 2'b00)
      $display("FAIL mid_rst_quiet got v=%b d=%b need 0,0", b.out_valid, b.nnz_done);
    else pass++;
    b.out_ready = 1'b1;
    drive(8'd3, 1'b1);
    total++;
    if ({b.out_valid, b.out_value, b.out_index, b.out_last,
         b.nnz_done, b.nnz_count} !== {1'b1, 8'd3, 8'd0, 1'b1, 1'b1, 9'd1})
      $display("FAIL mid_rst_next got v=%b val=%0d idx=%0d l=%b d=%b n=%0d need 1,3,0,1,1,1",
               b.out_valid, b.out_value, b.out_index, b.out_last,
               b.nnz_done, b.nnz_count);
    else pass++;
  endtask

  initial begin
    b.in_valid   = 1'b0;
    b.in_data    = '0;
    b.in_last    = 1'b0;
    b.out_ready  = 1'b0;
    b2.in_valid  = 1'b0;
    b2.in_data   = '0;
    b2.in_last   = 1'b0;
    b2.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_all_zero();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached pass=%0d total=%0d", pass, total);
    $fatal(1, "watchdog");
  end
endmodule
